// File: rtl/crate_hitmap_mapper.sv
// crate_hitmap_mapper: collects fibre-channel cluster hits over a fixed window
// after a frame-sync word and emits a one-cycle 2-D hit map for the rows
// owned by this crate, together with accepted-hit and dropped-hit counts.
module crate_hitmap_mapper #(
  parameter int NCH      = 16,
  parameter int ROW_LO   = 21,
  parameter int ROW_HI   = 30,
  parameter int NROW_OUT = 38,
  parameter int ROW_W    = 38,
  parameter int WIN      = 16,
  parameter int CRATE_ID = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [15:0]               fiber,
  input  logic [NCH*16-1:0]         fxch,
  output logic [37:0]               map_header,
  output logic [NROW_OUT*ROW_W-1:0] map_rows,
  output logic                      map_valid,
  output logic [15:0]               hit_cnt,
  output logic [7:0]                drop_cnt,
  output logic                      busy
);

  typedef enum logic [1:0] {IDLE, ACC, EMIT, CLR} state_t;

  localparam logic [15:0]      SYNC     = 16'hAAAA;
  localparam int               NR       = ROW_HI - ROW_LO + 1;
  localparam logic [6:0]       ROW_LO7  = 7'(ROW_LO);
  localparam logic [6:0]       ROW_HI7  = 7'(ROW_HI);
  // Column limit widened to 8 bits so a 7-bit gx of 64 still compares correctly.
  localparam logic [7:0]       ROW_W8   = (ROW_W > 255) ? 8'd255 : 8'(ROW_W);
  localparam logic [5:0]       WIN_LAST = 6'(WIN - 1);
  localparam logic [10:0]      CRATE11  = 11'(CRATE_ID);
  localparam logic [ROW_W-1:0] ONE      = {{(ROW_W-1){1'b0}}, 1'b1};

  state_t r_state;
  state_t w_nextState;

  logic [5:0]       r_winCnt;
  logic [ROW_W-1:0] r_map [NR];
  logic [15:0]      r_hitAcc;
  logic [7:0]       r_dropAcc;

  logic [37:0]               r_header;
  logic [NROW_OUT*ROW_W-1:0] r_rows;
  logic                      r_valid;
  logic [15:0]               r_hitOut;
  logic [7:0]                r_dropOut;

  logic [6:0]       w_gx [NCH];
  logic [6:0]       w_gy [NCH];
  logic [NCH-1:0]   w_inRow;
  logic [NCH-1:0]   w_inCol;
  logic [NCH-1:0]   w_unusedSpare;
  logic [ROW_W-1:0] w_setMask [NR];
  logic [15:0]      w_hitInc;
  logic [7:0]       w_dropInc;
  logic [16:0]      w_hitSum;
  logic [8:0]       w_dropSum;
  logic [NROW_OUT*ROW_W-1:0] w_rowsFlat;

  // Per-channel decode: 1-based global address (7 bits, no wrap) and ownership tests.
  for (genvar k = 0; k < NCH; k++) begin : g_chan
    assign w_gx[k]          = {1'b0, fxch[16*k+6 +: 6]} + 7'd1;
    assign w_gy[k]          = {1'b0, fxch[16*k +: 6]} + 7'd1;
    assign w_inRow[k]       = fxch[16*k+12] && (w_gy[k] >= ROW_LO7) && (w_gy[k] <= ROW_HI7);
    assign w_inCol[k]       = ({1'b0, w_gx[k]} < ROW_W8);
    assign w_unusedSpare[k] = ^fxch[16*k+13 +: 3];
  end

  // State register; reset drops any partially accumulated frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  // Next-state logic: sync only honoured from IDLE or CLR (back-to-back frames).
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (fiber == SYNC) w_nextState = ACC;
      ACC:     if (r_winCnt == WIN_LAST) w_nextState = EMIT;
      EMIT:    w_nextState = CLR;
      CLR:     w_nextState = (fiber == SYNC) ? ACC : IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Merge all channels of this cycle into per-row set masks and population counts.
  always_comb begin
    for (int r = 0; r < NR; r++) w_setMask[r] = '0;
    w_hitInc  = '0;
    w_dropInc = '0;
    for (int k = 0; k < NCH; k++) begin
      if (w_inRow[k]) begin
        if (w_inCol[k]) begin
          w_hitInc = w_hitInc + 16'd1;
          for (int r = 0; r < NR; r++) begin
            if (w_gy[k] == ROW_LO7 + 7'(r)) w_setMask[r] = w_setMask[r] | (ONE << w_gx[k]);
          end
        end else begin
          w_dropInc = w_dropInc + 8'd1;
        end
      end
    end
    w_hitSum  = {1'b0, r_hitAcc} + {1'b0, w_hitInc};
    w_dropSum = {1'b0, r_dropAcc} + {1'b0, w_dropInc};
  end

  // Place owned rows at their global slots; every other slot stays zero.
  always_comb begin
    w_rowsFlat = '0;
    for (int r = 0; r < NR; r++) w_rowsFlat[(ROW_LO+r)*ROW_W +: ROW_W] = r_map[r];
  end

  // Window counter, map and saturating counters; accumulate in ACC, wipe in CLR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_winCnt  <= '0;
      r_hitAcc  <= '0;
      r_dropAcc <= '0;
      for (int r = 0; r < NR; r++) r_map[r] <= '0;
    end else begin
      r_winCnt <= (r_state == ACC) ? r_winCnt + 6'd1 : 6'd0;
      if (r_state == ACC) begin
        for (int r = 0; r < NR; r++) r_map[r] <= r_map[r] | w_setMask[r];
        r_hitAcc  <= w_hitSum[16] ? 16'hFFFF : w_hitSum[15:0];
        r_dropAcc <= w_dropSum[8] ? 8'hFF : w_dropSum[7:0];
      end else if (r_state == CLR) begin
        for (int r = 0; r < NR; r++) r_map[r] <= '0;
        r_hitAcc  <= '0;
        r_dropAcc <= '0;
      end
    end
  end

  // Output frame registers: loaded only on the EMIT edge, zero on every other edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_header  <= '0;
      r_rows    <= '0;
      r_valid   <= 1'b0;
      r_hitOut  <= '0;
      r_dropOut <= '0;
    end else if (r_state == EMIT) begin
      r_header  <= {1'b1, CRATE11, fiber[9:0], SYNC};
      r_rows    <= w_rowsFlat;
      r_valid   <= 1'b1;
      r_hitOut  <= r_hitAcc;
      r_dropOut <= r_dropAcc;
    end else begin
      r_header  <= '0;
      r_rows    <= '0;
      r_valid   <= 1'b0;
      r_hitOut  <= '0;
      r_dropOut <= '0;
    end
  end

  assign map_header = r_header;
  assign map_rows   = r_rows;
  assign map_valid  = r_valid;
  assign hit_cnt    = r_hitOut;
  assign drop_cnt   = r_dropOut;
  assign busy       = (r_state != IDLE);

endmodule
